mips_multicycle_ctrl: RTL

- Multicycle successor to the single-cycle MIPS controller.
- Moore/Mealy FSM that sequences a shared-ALU, shared-memory datapath over several cycles per instruction.
- Handles variable-latency memory via a req/ready handshake with a timeout watchdog.
- Covers R-type (ADD/ADDU/SUB/SUBU/AND/OR/SLT/SLTU/NOP/JR), LW, SW, BEQ, ADDI, ADDIU, ORI, LUI, J, JAL; reports illegal opcodes and memory timeouts.

---
 rtl/mips_multicycle_ctrl.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences a shared-ALU, shared-memory datapath.
// Memory accesses use a memreq/memready handshake guarded by a timeout watchdog.
// Ports:
//   clk, reset (async, active-high)
//   op, funct      : instruction fields from the instruction register
//   memready       : memory completes the current access this cycle
//   memreq/memwrite/iord, irwrite, pcwrite, pcwritecond, bne, pcsrc,
//   alusrca, alusrcb, signext, shiftl16, alucontrol, regwrite, regdst,
//   memtoreg       : datapath controls
//   fault/fault_code : sticky fault flag (01 illegal instr, 10 mem timeout)
//   state          : current FSM state (debug)
// Optional macro MIPS_MC_BNE_EN: adds BNE (op 000101) through the BRANCH state.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       memready,
    output logic       memreq,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       bne,
    output logic [1:0] pcsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic       signext,
    output logic       shiftl16,
    output logic [3:0] alucontrol,
    output logic       regwrite,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_JR     = 4'd14,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;

    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'(MEM_TIMEOUT == 0 ? 0 : MEM_TIMEOUT - 1);

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    logic             rtype_ok;
    logic [3:0]       rtype_alu;
    logic             mem_entry;

    // Only meaningful while memreq is high; memready in the same cycle wins.
    assign timed_out = (MEM_TIMEOUT != 0) && !memready && (wait_cnt == TO_LAST);

    assign state = cur_state;

    assign mem_entry = (nxt_state != cur_state) &&
                       (nxt_state == S_FETCH || nxt_state == S_MEMRD ||
                        nxt_state == S_MEMWR);

    always_comb begin
        rtype_ok  = 1'b1;
        rtype_alu = ALU_ADD;
        case (funct)
            6'b100000, 6'b100001: rtype_alu = ALU_ADD;
            6'b100010, 6'b100011: rtype_alu = ALU_SUB;
            6'b100100:            rtype_alu = ALU_AND;
            6'b100101, 6'b000000: rtype_alu = ALU_OR;
            6'b101010:            rtype_alu = ALU_SLT;
            6'b101011:            rtype_alu = ALU_SLTU;
            default:              rtype_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state  <= S_IDLE;
            wait_cnt   <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            cur_state <= nxt_state;
            if (mem_entry)
                wait_cnt <= '0;
            else if (memreq && !memready)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (nxt_state == S_FAULT && cur_state != S_FAULT) begin
                fault      <= 1'b1;
                // DECODE is the only source of illegal-instruction faults.
                fault_code <= (cur_state == S_DECODE) ? 2'b01 : 2'b10;
            end
        end
    end

    always_comb begin
        nxt_state   = cur_state;
        memreq      = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        irwrite     = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        bne         = 1'b0;
        pcsrc       = 2'b00;
        alusrca     = 2'b00;
        alusrcb     = 2'b00;
        signext     = 1'b0;
        shiftl16    = 1'b0;
        alucontrol  = ALU_ADD;
        regwrite    = 1'b0;
        regdst      = 2'b00;
        memtoreg    = 2'b00;
        unique case (cur_state)
            S_IDLE: nxt_state = S_FETCH;
            S_FETCH: begin
                memreq  = 1'b1;
                alusrcb = 2'b01;
                if (memready) begin
                    irwrite   = 1'b1;
                    pcwrite   = 1'b1;
                    nxt_state = S_DECODE;
                end else if (timed_out) begin
                    nxt_state = S_FAULT;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                signext = 1'b1;
                case (op)
                    6'b000000: begin
                        if (funct == 6'b001000) nxt_state = S_JR;
                        else if (rtype_ok)      nxt_state = S_EXEC;
                        else                    nxt_state = S_FAULT;
                    end
                    6'b100011, 6'b101011: nxt_state = S_MEMADR;
                    6'b000100:            nxt_state = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
                    6'b000101:            nxt_state = S_BRANCH;
`endif
                    6'b001000, 6'b001001,
                    6'b001101, 6'b001111: nxt_state = S_IEXEC;
                    6'b000010:            nxt_state = S_JUMP;
                    6'b000011:            nxt_state = S_JAL;
                    default:              nxt_state = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                signext   = 1'b1;
                nxt_state = (op == 6'b101011) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memreq = 1'b1;
                iord   = 1'b1;
                if (memready)       nxt_state = S_MEMWB;
                else if (timed_out) nxt_state = S_FAULT;
            end
            S_MEMWB: begin
                regwrite  = 1'b1;
                memtoreg  = 2'b01;
                nxt_state = S_FETCH;
            end
            S_MEMWR: begin
                memreq   = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
                if (memready)       nxt_state = S_FETCH;
                else if (timed_out) nxt_state = S_FAULT;
            end
            S_EXEC: begin
                alusrca    = 2'b01;
                alucontrol = rtype_alu;
                nxt_state  = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite  = 1'b1;
                regdst    = 2'b01;
                nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                alusrca     = 2'b01;
                alucontrol  = ALU_SUB;
                pcsrc       = 2'b01;
                pcwritecond = 1'b1;
`ifdef MIPS_MC_BNE_EN
                bne         = (op == 6'b000101);
`endif
                nxt_state   = S_FETCH;
            end
            S_IEXEC: begin
                alusrcb = 2'b10;
                case (op)
                    6'b001101: begin
                        alusrca    = 2'b01;
                        alucontrol = ALU_OR;
                    end
                    6'b001111: begin
                        alusrca  = 2'b10;
                        shiftl16 = 1'b1;
                    end
                    default: begin
                        alusrca = 2'b01;
                        signext = 1'b1;
                    end
                endcase
                nxt_state = S_IWB;
            end
            S_IWB: begin
                regwrite  = 1'b1;
                nxt_state = S_FETCH;
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                pcwrite   = 1'b1;
                nxt_state = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4, so it is the link value.
                pcsrc     = 2'b10;
                pcwrite   = 1'b1;
                regwrite  = 1'b1;
                regdst    = 2'b10;
                memtoreg  = 2'b10;
                nxt_state = S_FETCH;
            end
            S_JR: begin
                pcsrc     = 2'b11;
                pcwrite   = 1'b1;
                nxt_state = S_FETCH;
            end
            S_FAULT: alucontrol = 4'b0000;
        endcase
    end

endmodule
